// File: rtl/half_subtractor.sv
// Registered half subtractor with a saturating borrow event counter.
// Ports: clk, rst (sync, active-high); in_valid/A/B in; out_valid/D/Bout, borrow_cnt/cnt_sat out.
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic [CNT_W-1:0] borrow_cnt,
  output logic             cnt_sat
);

  // One extra bit catches the borrow: it is set exactly when A < B.
  logic [WIDTH:0] diff_ext;
  logic           borrow;

  always_comb begin
    diff_ext = {1'b0, A} - {1'b0, B};
    borrow   = diff_ext[WIDTH];
  end

  assign cnt_sat = &borrow_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      D          <= '0;
      Bout       <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D    <= diff_ext[WIDTH-1:0];
        Bout <= borrow;
        if (borrow && !cnt_sat)
          borrow_cnt <= borrow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor at three widths.
// Shared stimulus; each DUT has its own expected queue and monitor check.
module tb_half_subtractor;

  typedef struct {
    int d;
    int bo;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       v1, b1, s1;
  logic [0:0] d1;
  logic [7:0] c1;
  logic       v4, b4, s4;
  logic [3:0] d4;
  logic [1:0] c4;
  logic       v8, b8, s8;
  logic [7:0] d8;
  logic [7:0] c8;

  int   total = 0;
  int   bad = 0;
  bit   armed = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t h1, h4, h8;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a[0:0]), .B(b[0:0]), .out_valid(v1),
    .D(d1), .Bout(b1), .borrow_cnt(c1), .cnt_sat(s1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a[3:0]), .B(b[3:0]), .out_valid(v4),
    .D(d4), .Bout(b4), .borrow_cnt(c4), .cnt_sat(s4)
  );

  half_subtractor #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a), .B(b), .out_valid(v8),
    .D(d8), .Bout(b8), .borrow_cnt(c8), .cnt_sat(s8)
  );

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference rule: D = (A-B) mod 2^w, borrow = A<B, counter saturates.
  function automatic exp_t step(input exp_t h, input int w,
                                input int cw, input int av,
                                input int bv);
    exp_t e;
    int   m;
    int   x;
    int   y;
    m = (1 << w) - 1;
    x = av & m;
    y = bv & m;
    e.d = (x - y) & m;
    e.bo = (x < y) ? 1 : 0;
    e.cnt = h.cnt;
    if (e.bo == 1 && h.cnt < (1 << cw) - 1)
      e.cnt = h.cnt + 1;
    return e;
  endfunction

  task automatic drive(input bit r, input bit v,
                       input int av, input int bv);
    @(negedge clk);
    #1;
    rst = r;
    in_valid = v;
    a = av[7:0];
    b = bv[7:0];
    armed = 1;
    if (r) begin
      h1 = '{0, 0, 0};
      h4 = '{0, 0, 0};
      h8 = '{0, 0, 0};
      q1.delete();
      q4.delete();
      q8.delete();
    end else if (v) begin
      h1 = step(h1, 1, 8, av, bv);
      h4 = step(h4, 4, 2, av, bv);
      h8 = step(h8, 8, 8, av, bv);
      q1.push_back(h1);
      q4.push_back(h4);
      q8.push_back(h8);
    end
  endtask

  task automatic mon(input string nm, input logic ov,
                     input int ad, input logic ab,
                     input int ac, input logic as,
                     input int cmax, input exp_t hold,
                     inout exp_t q[$]);
    exp_t e;
    if (ov === 1'b1) begin
      if (q.size() == 0) begin
        chk({nm, " spurious out_valid"}, 1, 0);
        return;
      end
      e = q.pop_front();
    end else begin
      chk({nm, " out_valid"}, int'(ov), 0);
      if (q.size() != 0) begin
        chk({nm, " missing result"}, 0, 1);
        void'(q.pop_front());
      end
      e = hold;
    end
    chk({nm, " D"}, ad, e.d);
    chk({nm, " Bout"}, int'(ab), e.bo);
    chk({nm, " borrow_cnt"}, ac, e.cnt);
    chk({nm, " cnt_sat"}, int'(as), (e.cnt == cmax) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon("w1", v1, int'(d1), b1, int'(c1), s1, 255, h1, q1);
      mon("w4", v4, int'(d4), b4, int'(c4), s4, 3, h4, q4);
      mon("w8", v8, int'(d8), b8, int'(c8), s8, 255, h8, q8);
    end
  end

  initial begin
    h1 = '{0, 0, 0};
    h4 = '{0, 0, 0};
    h8 = '{0, 0, 0};
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 1);
    drive(0, 1, 3, 5);
    drive(0, 1, 9, 9);
    drive(0, 1, 0, 255);
    drive(0, 1, 0, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 1, 0, 1);
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 1, 1, 1);
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
            $urandom_range(0, 255), $urandom_range(0, 255));
    end
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("queues drained", q1.size() + q4.size() + q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 Parameter: WIDTH, default 1, operand/difference width in bits (legal 1..32).
REQ-002 Parameter: CNT_W, default 8, width of borrow event counter (legal 1..16).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  A/B qualify this cycle.
REQ-006 Port: A  input  WIDTH  minuend.
REQ-007 Port: B  input  WIDTH  subtrahend.
REQ-008 Port: out_valid  output  1  D/Bout hold a fresh result.
REQ-009 Port: D  output  WIDTH  registered difference.
REQ-010 Port: Bout  output  1  registered borrow-out.
REQ-011 Port: borrow_cnt  output  CNT_W  count of accepted operations with borrow.
REQ-012 Port: cnt_sat  output  1  borrow_cnt has reached all-ones.

Function
REQ-013 On rising edge with in_valid=1 and rst=0, D SHALL load (A - B) mod 2^WIDTH.
REQ-014 Same edge: Bout SHALL load 1 when A < B unsigned, else 0.
REQ-015 For WIDTH=1: D = A XOR B, Bout = (NOT A) AND B; truth table 00->0/0, 01->1/1, 10->1/0, 11->0/0.
REQ-016 Latency SHALL be exactly one clock: inputs sampled at edge N appear on D/Bout after edge N.
REQ-017 out_valid SHALL be a registered copy of in_valid (1 the cycle after an accepted input, else 0).
REQ-018 When in_valid=0, D and Bout SHALL hold their previous values; only out_valid drops.
REQ-019 No back-pressure; every in_valid=1 cycle is accepted; back-to-back inputs produce back-to-back results.
REQ-020 borrow_cnt SHALL increment by 1 on each accepted operation whose borrow result is 1.
REQ-021 borrow_cnt SHALL saturate at 2^CNT_W - 1; no wrap-around.
REQ-022 cnt_sat SHALL be combinational: 1 exactly when borrow_cnt is all-ones.
REQ-023 A = B SHALL yield D = 0, Bout = 0; A = 0, B = 2^WIDTH-1 SHALL yield D = 1, Bout = 1.
REQ-024 Outputs SHALL never be X after the first reset edge, for any known inputs.

Reset
REQ-025 With rst=1 at a rising edge: D=0, Bout=0, out_valid=0, borrow_cnt=0 after that edge.
REQ-026 rst SHALL take priority over in_valid on the same edge; that input is discarded.
REQ-027 Reset asserted mid-stream SHALL clear all state; first post-reset in_valid cycle behaves as from power-up.
REQ-028 rst has no asynchronous effect; between edges outputs hold.

Verification
REQ-029 WIDTH=1, in_valid=1, drive A/B = 00,01,10,11 on successive edges -> D/Bout = 0/0, 1/1, 1/0, 0/0 one cycle later; out_valid=1 each cycle.
REQ-030 WIDTH=4, A=3, B=5, in_valid=1 -> next cycle D=14, Bout=1; then A=9, B=9 -> D=0, Bout=0.
REQ-031 Valid gap: result D=1,Bout=1, then in_valid=0 with A=1,B=0 -> out_valid=0, D/Bout stay 1/1.
REQ-032 CNT_W=2, five consecutive borrow ops -> borrow_cnt 1,2,3,3,3; cnt_sat=1 from the third onward.
REQ-033 rst=1 and in_valid=1 with A=0,B=1 on same edge -> all outputs 0, borrow_cnt=0 afterward.
REQ-034 Random 1000 cycles, WIDTH=8, random in_valid -> outputs match one-cycle-delayed reference model.
